// File: rtl/fan_speed_controller.sv
// Fan speed controller: power/speed/timer pulses drive a soft-ramped PWM motor output
// with a seconds-based auto-off countdown.
module fan_speed_controller #(
  parameter int unsigned CLK_HZ      = 1000,
  parameter int unsigned PWM_PERIOD  = 10,
  parameter int unsigned DUTY1       = 4,
  parameter int unsigned DUTY2       = 7,
  parameter int unsigned DUTY3       = 10,
  parameter int unsigned RAMP_FRAMES = 2,
  parameter int unsigned TIMER_STEP  = 30,
  parameter int unsigned TIMER_MAX   = 240,
  localparam int unsigned DW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          power_pulse,
  input  logic          speed_pulse,
  input  logic          timer_pulse,
  output logic          pwm_out,
  output logic [1:0]    speed_level,
  output logic [DW-1:0] duty_cur,
  output logic [7:0]    timer_remain,
  output logic          running
);

  localparam int unsigned PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int unsigned SW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned RW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

  typedef enum logic [1:0] {StOff, StRamp, StRun} state_e;

  state_e        state_q, state_d;
  logic [1:0]    speed_q, speed_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [7:0]    timer_q, timer_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic [PW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic          pwm_q, pwm_d;

  logic [DW-1:0] target;
  logic [7:0]    timer_base;
  logic [8:0]    timer_sum;
  logic          frame_end, sec_last, expire;

  assign frame_end = (pwm_cnt_q == PW'(PWM_PERIOD - 1));
  assign sec_last  = (sec_cnt_q == SW'(CLK_HZ - 1));
  assign expire    = (timer_q == 8'd1) && sec_last;

  always_comb begin
    case (speed_q)
      2'd1:    target = DW'(DUTY1);
      2'd2:    target = DW'(DUTY2);
      2'd3:    target = DW'(DUTY3);
      default: target = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    duty_d     = duty_q;
    timer_d    = timer_q;
    sec_cnt_d  = sec_cnt_q;
    ramp_cnt_d = ramp_cnt_q;
    timer_base = timer_q;
    timer_sum  = '0;
    pwm_cnt_d  = frame_end ? '0 : pwm_cnt_q + PW'(1);
    pwm_d      = (32'(pwm_cnt_q) < 32'(duty_q));

    case (state_q)
      StOff: begin
        if (power_pulse) begin
          state_d    = StRamp;
          speed_d    = 2'd1;
          ramp_cnt_d = '0;
        end
      end
      default: begin
        if (power_pulse || expire) begin
          state_d    = StOff;
          speed_d    = '0;
          duty_d     = '0;
          timer_d    = '0;
          sec_cnt_d  = '0;
          ramp_cnt_d = '0;
        end else begin
          if (timer_q != 8'd0) begin
            if (sec_last) begin
              sec_cnt_d  = '0;
              timer_base = timer_q - 8'd1;
            end else begin
              sec_cnt_d = sec_cnt_q + SW'(1);
            end
          end
          timer_d = timer_base;
          // A pulse at the ceiling cancels; otherwise add and clamp via the 9-bit sum.
          if (timer_pulse) begin
            timer_sum = {1'b0, timer_base} + 9'(TIMER_STEP);
            if (timer_base == 8'(TIMER_MAX)) begin
              timer_d = '0;
            end else if (timer_sum >= 9'(TIMER_MAX)) begin
              timer_d = 8'(TIMER_MAX);
            end else begin
              timer_d = timer_sum[7:0];
            end
          end
          if (timer_d == 8'd0) begin
            sec_cnt_d = '0;
          end

          if (speed_pulse) begin
            speed_d    = (speed_q == 2'd3) ? 2'd1 : speed_q + 2'd1;
            state_d    = StRamp;
            ramp_cnt_d = '0;
          end else if (state_q == StRamp && frame_end) begin
            if (duty_q == target) begin
              state_d = StRun;
            end else if (ramp_cnt_q == RW'(RAMP_FRAMES - 1)) begin
              ramp_cnt_d = '0;
              duty_d     = (duty_q < target) ? duty_q + DW'(1) : duty_q - DW'(1);
            end else begin
              ramp_cnt_d = ramp_cnt_q + RW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StOff;
      speed_q    <= '0;
      duty_q     <= '0;
      timer_q    <= '0;
      sec_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      ramp_cnt_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      duty_q     <= duty_d;
      timer_q    <= timer_d;
      sec_cnt_q  <= sec_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      ramp_cnt_q <= ramp_cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign speed_level  = speed_q;
  assign duty_cur     = duty_q;
  assign timer_remain = timer_q;
  assign running      = (state_q != StOff);

endmodule

// File: tb/tb_fan_speed_controller.sv
// Directed bench for fan_speed_controller with a short timer (step 2 s, max 6 s).
module tb_fan_speed_controller;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       power_pulse = 1'b0;
  logic       speed_pulse = 1'b0;
  logic       timer_pulse = 1'b0;
  logic       pwm_out;
  logic [1:0] speed_level;
  logic [3:0] duty_cur;
  logic [7:0] timer_remain;
  logic       running;

  int total = 0;
  int bad = 0;

  fan_speed_controller #(
    .CLK_HZ     (1000),
    .PWM_PERIOD (10),
    .DUTY1      (4),
    .DUTY2      (7),
    .DUTY3      (10),
    .RAMP_FRAMES(2),
    .TIMER_STEP (2),
    .TIMER_MAX  (6)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .power_pulse (power_pulse),
    .speed_pulse (speed_pulse),
    .timer_pulse (timer_pulse),
    .pwm_out     (pwm_out),
    .speed_level (speed_level),
    .duty_cur    (duty_cur),
    .timer_remain(timer_remain),
    .running     (running)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds the chosen pulses for exactly one rising edge.
  task automatic pulse(input logic p, input logic s, input logic t);
    power_pulse = p;
    speed_pulse = s;
    timer_pulse = t;
    @(negedge clk_in);
    power_pulse = 1'b0;
    speed_pulse = 1'b0;
    timer_pulse = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_duty(input int exp, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (int'(duty_cur) != exp && n < limit);
  endtask

  task automatic wait_off(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (running && n < limit);
  endtask

  task automatic count_pwm(input int len, output int ones);
    ones = 0;
    repeat (len) begin
      @(negedge clk_in);
      if (pwm_out) ones++;
    end
  endtask

  initial begin
    int n;
    int ones;

    // Reset
    cycles(5);
    rst_n = 1'b1;
    check("rst_running", running, 0);
    check("rst_speed", speed_level, 0);
    check("rst_duty", duty_cur, 0);
    check("rst_timer", timer_remain, 0);
    count_pwm(100, ones);
    check("rst_pwm_quiet", ones, 0);

    // Power on and first ramp 0 -> 4
    pulse(1'b1, 1'b0, 1'b0);
    check("pon_running", running, 1);
    check("pon_speed", speed_level, 1);
    check("pon_duty", duty_cur, 0);
    wait_duty(1, 40, n);
    check("ramp_d1", duty_cur, 1);
    check("ramp_d1_time", int'(n >= 11 && n <= 20), 1);
    wait_duty(2, 40, n);
    check("ramp_d2_time", n, 20);
    wait_duty(3, 40, n);
    check("ramp_d3_time", n, 20);
    wait_duty(4, 40, n);
    check("ramp_d4_time", n, 20);
    cycles(20);
    count_pwm(10, ones);
    check("pwm_duty4", ones, 4);
    cycles(50);
    check("run_duty_hold", duty_cur, 4);

    // Speed 1 -> 2 -> 3 -> 1
    pulse(1'b0, 1'b1, 1'b0);
    check("spd2_level", speed_level, 2);
    wait_duty(7, 100, n);
    check("spd2_duty", duty_cur, 7);
    check("spd2_time", int'(n >= 51 && n <= 60), 1);
    cycles(20);
    pulse(1'b0, 1'b1, 1'b0);
    check("spd3_level", speed_level, 3);
    wait_duty(10, 100, n);
    check("spd3_duty", duty_cur, 10);
    cycles(3);
    count_pwm(20, ones);
    check("pwm_duty10", ones, 20);
    pulse(1'b0, 1'b1, 1'b0);
    check("spd1_wrap", speed_level, 1);
    wait_duty(4, 200, n);
    check("spd1_duty", duty_cur, 4);
    check("spd1_time", int'(n >= 111 && n <= 120), 1);
    cycles(20);

    // Timer: two pulses -> 4 s, then auto-off
    pulse(1'b0, 1'b0, 1'b1);
    check("tmr_first", timer_remain, 2);
    pulse(1'b0, 1'b0, 1'b1);
    check("tmr_second", timer_remain, 4);
    cycles(1500);
    check("tmr_mid", timer_remain, 3);
    wait_off(3000, n);
    check("tmr_off_time", n + 1500, 3999);
    check("tmr_off_timer", timer_remain, 0);
    check("tmr_off_speed", speed_level, 0);
    cycles(2);
    count_pwm(20, ones);
    check("tmr_off_pwm", ones, 0);

    // Timer ignored while OFF
    pulse(1'b0, 1'b0, 1'b1);
    check("tmr_while_off", timer_remain, 0);

    // Timer saturate then cancel
    pulse(1'b1, 1'b0, 1'b0);
    cycles(5);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    check("tmr_max", timer_remain, 6);
    pulse(1'b0, 1'b0, 1'b1);
    check("tmr_cancel", timer_remain, 0);
    check("tmr_cancel_run", running, 1);

    // Power with speed in RUN -> OFF
    wait_duty(4, 200, n);
    cycles(20);
    pulse(1'b1, 1'b1, 1'b0);
    check("col_pwr_running", running, 0);
    check("col_pwr_speed", speed_level, 0);
    check("col_pwr_duty", duty_cur, 0);

    // Timer pulse in the expiry cycle
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check("exp_load", timer_remain, 2);
    cycles(1999);
    check("exp_last_sec", timer_remain, 1);
    check("exp_still_on", running, 1);
    pulse(1'b0, 1'b0, 1'b1);
    check("exp_off", running, 0);
    check("exp_timer", timer_remain, 0);

    // Async reset mid-ramp
    pulse(1'b1, 1'b0, 1'b0);
    cycles(25);
    check("mid_ramp_duty", duty_cur, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_running", running, 0);
    check("arst_speed", speed_level, 0);
    check("arst_duty", duty_cur, 0);
    check("arst_pwm", pwm_out, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    cycles(3);
    check("arst_stays_off", running, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
